// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID pipeline register: a main entry feeding Decode plus one skid
// entry, valid/ready handshake toward Fetch, flush, and two saturating counters.
module if_id_skid_reg #(
  parameter int INS_W = 32,
  parameter int PC_W  = 7,
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*INS_W-1:0] ins_f,
  input  logic [LANES-1:0]       lane_mask_f,
  input  logic [PC_W-1:0]        pc_plus1_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  output logic                   valid_d,
  output logic [LANES*INS_W-1:0] ins_d,
  output logic [LANES-1:0]       lane_mask_d,
  output logic [PC_W-1:0]        pc_plus1_d,
  output logic [CNT_W-1:0]       flush_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  typedef struct packed {
    logic [LANES*INS_W-1:0] ins;
    logic [LANES-1:0]       mask;
    logic [PC_W-1:0]        pc;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  entry_t           main_q, main_d, skid_q, skid_d, in_entry;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic             accept, consume;

  assign in_entry = '{ins: ins_f, mask: lane_mask_f, pc: pc_plus1_f};
  // in_ready comes straight from a flop, so Fetch sees no path from stall_d.
  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign consume  = main_vld_q & ~stall_d;

  // NOTE: combinational next-state uses blocking '=' with every output defaulted
  // first, so no latch is inferred; the state flops below use non-blocking '<='.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_vld_d   = main_vld_q;
    skid_vld_d   = skid_vld_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush_d) begin
      main_d     = '0;
      skid_d     = '0;
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || consume) begin
      // Main is free this edge; the skid entry is older than anything on the input.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_entry;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_entry;
      skid_vld_d = 1'b1;
    end

    if (flush_d && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    if (!main_vld_q && !stall_d && !flush_d && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  // NOTE: payload registers are reset too, so Decode sees an all-zero NOP
  // rather than stale or undefined data after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_vld_q   <= main_vld_d;
      skid_vld_q   <= skid_vld_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_d     = main_vld_q;
  assign ins_d       = main_q.ins;
  assign lane_mask_d = main_q.mask;
  assign pc_plus1_d  = main_q.pc;
  assign flush_cnt   = flush_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg (LANES=2, CNT_W=4): a per-cycle vector
// table followed by hand-written bubble-saturation and mid-operation reset sequences.
module tb_if_id_skid_reg;

  localparam int INS_W = 32;
  localparam int PC_W  = 7;
  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam int IW    = LANES * INS_W;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, stall_d, flush_d, valid_d;
  logic [IW-1:0]    ins_f, ins_d;
  logic [LANES-1:0] lane_mask_f, lane_mask_d;
  logic [PC_W-1:0]  pc_plus1_f, pc_plus1_d;
  logic [CNT_W-1:0] flush_cnt, bubble_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_skid_reg #(.INS_W(INS_W), .PC_W(PC_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins_f(ins_f), .lane_mask_f(lane_mask_f), .pc_plus1_f(pc_plus1_f),
    .stall_d(stall_d), .flush_d(flush_d), .valid_d(valid_d), .ins_d(ins_d),
    .lane_mask_d(lane_mask_d), .pc_plus1_d(pc_plus1_d),
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n, in_valid, stall, flush;
    logic [IW-1:0]    ins;
    logic [LANES-1:0] mask;
    logic [PC_W-1:0]  pc;
    logic             e_valid, e_ready;
    logic [IW-1:0]    e_ins;
    logic [LANES-1:0] e_mask;
    logic [PC_W-1:0]  e_pc;
    logic [CNT_W-1:0] e_fcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic st, logic fl, logic [IW-1:0] in_i,
                              logic [LANES-1:0] m, logic [PC_W-1:0] p, logic ev,
                              logic [IW-1:0] ei, logic [LANES-1:0] em, logic [PC_W-1:0] ep,
                              logic er, logic [CNT_W-1:0] ef);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.stall = st; v.flush = fl;
    v.ins = in_i; v.mask = m; v.pc = p;
    v.e_valid = ev; v.e_ins = ei; v.e_mask = em; v.e_pc = ep; v.e_ready = er; v.e_fcnt = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic st, input logic fl,
                       input logic [IW-1:0] in_i, input logic [LANES-1:0] m,
                       input logic [PC_W-1:0] p);
    rst_n = r; in_valid = iv; stall_d = st; flush_d = fl;
    ins_f = in_i; lane_mask_f = m; pc_plus1_f = p;
  endtask

  // One edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [IW-1:0] I0 = 64'h0000_0000_00A0_0013;
  localparam logic [IW-1:0] IA = 64'h0000_0000_AAAA_0001;
  localparam logic [IW-1:0] IB = 64'h0000_0000_BBBB_0002;
  localparam logic [IW-1:0] IC = 64'h0000_0000_CCCC_0003;
  localparam logic [IW-1:0] IL = {32'h1111_1111, 32'h2222_2222};
  localparam logic [IW-1:0] IM = {32'h3333_3333, 32'h4444_4444};
  localparam logic [IW-1:0] ID = 64'hDDDD_DDDD_DDDD_0004;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    //             rst iv st fl ins  mask   pc  | vld ins  mask   pc  rdy fcnt
    vecs.push_back(mk(0, 1, 0, 0, I0, 2'b01, 5,   0, '0,  2'b00, 0,  1, 0)); // reset held
    vecs.push_back(mk(0, 1, 0, 0, I0, 2'b01, 5,   0, '0,  2'b00, 0,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0, I0, 2'b01, 5,   1, I0,  2'b01, 5,  1, 0)); // 1-cycle latency
    vecs.push_back(mk(1, 0, 0, 0, '0, 2'b00, 0,   0, I0,  2'b01, 5,  1, 0)); // drained, payload held
    vecs.push_back(mk(1, 1, 0, 0, IA, 2'b01, 1,   1, IA,  2'b01, 1,  1, 0)); // A into main
    vecs.push_back(mk(1, 1, 1, 0, IB, 2'b11, 2,   1, IA,  2'b01, 1,  0, 0)); // B into skid
    vecs.push_back(mk(1, 1, 1, 0, IC, 2'b10, 3,   1, IA,  2'b01, 1,  0, 0)); // C held off
    vecs.push_back(mk(1, 1, 0, 0, IC, 2'b10, 3,   1, IB,  2'b11, 2,  1, 0)); // skid -> main
    vecs.push_back(mk(1, 1, 0, 0, IC, 2'b10, 3,   1, IC,  2'b10, 3,  1, 0)); // C accepted
    vecs.push_back(mk(1, 0, 0, 0, '0, 2'b00, 0,   0, IC,  2'b10, 3,  1, 0));
    vecs.push_back(mk(1, 1, 1, 0, IA, 2'b01, 1,   1, IA,  2'b01, 1,  1, 0)); // empty main ignores stall
    vecs.push_back(mk(1, 1, 1, 0, IB, 2'b11, 2,   1, IA,  2'b01, 1,  0, 0));
    vecs.push_back(mk(1, 1, 1, 1, IC, 2'b10, 3,   0, '0,  2'b00, 0,  1, 1)); // flush over stall
    vecs.push_back(mk(1, 0, 0, 0, '0, 2'b00, 0,   0, '0,  2'b00, 0,  1, 1)); // C never appears
    vecs.push_back(mk(1, 1, 0, 0, IL, 2'b01, 9,   1, IL,  2'b01, 9,  1, 1)); // two lanes
    vecs.push_back(mk(1, 1, 0, 0, IM, 2'b00, 10,  1, IM,  2'b00, 10, 1, 1)); // mask 0 delivered
    vecs.push_back(mk(1, 0, 0, 0, '0, 2'b00, 0,   0, IM,  2'b00, 10, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, ID, 2'b11, 4,   0, '0,  2'b00, 0,  1, 2)); // consecutive flushes
    vecs.push_back(mk(1, 1, 0, 1, ID, 2'b11, 4,   0, '0,  2'b00, 0,  1, 3));
    vecs.push_back(mk(1, 0, 0, 0, '0, 2'b00, 0,   0, '0,  2'b00, 0,  1, 3));

    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].in_valid, vecs[i].stall, vecs[i].flush,
            vecs[i].ins, vecs[i].mask, vecs[i].pc);
      step();
      check($sformatf("v%0d valid_d", i),     64'(valid_d),     64'(vecs[i].e_valid));
      check($sformatf("v%0d ins_d", i),       64'(ins_d),       64'(vecs[i].e_ins));
      check($sformatf("v%0d lane_mask_d", i), 64'(lane_mask_d), 64'(vecs[i].e_mask));
      check($sformatf("v%0d pc_plus1_d", i),  64'(pc_plus1_d),  64'(vecs[i].e_pc));
      check($sformatf("v%0d in_ready", i),    64'(in_ready),    64'(vecs[i].e_ready));
      check($sformatf("v%0d flush_cnt", i),   64'(flush_cnt),   64'(vecs[i].e_fcnt));
    end

    // Bubble counting and saturation at 2^CNT_W-1.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("bub reset", 64'(bubble_cnt), 64'd0);
    check("fcnt reset", 64'(flush_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 10; k++) step();
    check("bub 10", 64'(bubble_cnt), 64'd10);
    stall_d = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("bub stall no count", 64'(bubble_cnt), 64'd10);
    stall_d = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("bub sat", 64'(bubble_cnt), 64'd15);
    step();
    check("bub sat hold", 64'(bubble_cnt), 64'd15);

    // Reset with main and skid both full and Decode stalled.
    drive(1'b1, 1'b1, 1'b1, 1'b0, IA, 2'b01, 1);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, IB, 2'b11, 2);
    step();
    check("mid full ready", 64'(in_ready), 64'd0);
    check("mid full main", 64'(ins_d), 64'(IA));
    drive(1'b0, 1'b1, 1'b1, 1'b1, IC, 2'b10, 3);
    step();
    check("mid rst valid", 64'(valid_d), 64'd0);
    check("mid rst ins", 64'(ins_d), 64'd0);
    check("mid rst ready", 64'(in_ready), 64'd1);
    check("mid rst bub", 64'(bubble_cnt), 64'd0);
    check("mid rst fcnt", 64'(flush_cnt), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, ID, 2'b11, 4);
    step();
    check("post rst valid", 64'(valid_d), 64'd1);
    check("post rst ins", 64'(ins_d), 64'(ID));
    check("post rst pc", 64'(pc_plus1_d), 64'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("post rst alone", 64'(valid_d), 64'd0);
    step();
    check("post rst no ghost", 64'(valid_d), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised, elastic IF/ID pipeline register for the next-generation core.
- Carries a bundle of LANES instructions, a per-lane valid mask and PC+1 from Fetch to Decode using a valid/ready handshake.
- Holds a main entry plus one skid entry, so the Fetch side never loses an instruction when Decode stalls.
- Flush from Decode kills both entries and zeroes the payload. Two saturating counters record flushes and bubbles.

Parameters:
- INS_W, 32, instruction width per lane
- PC_W, 7, PC+1 width
- LANES, 1, instructions per fetch bundle (1..4)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  Fetch presents a bundle
- in_ready  out  1  stage can accept a bundle; equals ~skid_valid (registered, no combinational path)
- ins_f  in  LANES*INS_W  instruction bundle, lane 0 in LSBs
- lane_mask_f  in  LANES  per-lane valid mask
- pc_plus1_f  in  PC_W  PC+1 of lane 0
- stall_d  in  1  Decode cannot consume (acts as ~out_ready)
- flush_d  in  1  branch/jump redirect; kill all held bundles
- valid_d  out  1  main entry holds a bundle
- ins_d  out  LANES*INS_W  main entry instructions
- lane_mask_d  out  LANES  main entry mask
- pc_plus1_d  out  PC_W  main entry PC+1
- flush_cnt  out  CNT_W  number of cycles with flush_d=1, saturating
- bubble_cnt  out  CNT_W  number of cycles with valid_d=0, stall_d=0 and flush_d=0, saturating

Behaviour:
Reset and storage
- rst_n=0 at a clock edge: main and skid entries become invalid; all payload registers become 0; both counters become 0; in_ready=1 on the next cycle.
- Reset takes priority over flush and over any handshake activity.
- Storage consists of the main entry (drives the *_d outputs) and the skid entry (internal); each has a valid bit.

Handshake definitions
- Accept occurs when in_valid & in_ready.
- Consume occurs when valid_d & ~stall_d.
- Latency from an accept into an empty stage to valid_d is 1 cycle.

Transitions with flush_d=0 (evaluated at each edge)
- Main empty, accept: the incoming bundle loads main.
- Main full, consume, skid empty, accept: the incoming bundle loads main.
- Main full, consume, skid empty, no accept: main becomes invalid.
- Main full, no consume, accept: the incoming bundle loads skid (this requires skid empty); in_ready=0 on the next cycle.
- Main full, consume, skid full: skid moves to main and skid becomes invalid. No accept is possible because in_ready=0. in_ready=1 on the next cycle.
- Main full, no consume, skid full: hold both entries.

Ordering and payload rules
- Order is strictly FIFO; a bundle is never duplicated or dropped except by flush.
- Payload registers hold their value while no load occurs. The outputs are stable while valid_d & stall_d.
- lane_mask travels with its bundle unchanged. A bundle with mask 0 is still a valid entry and is delivered.

Flush
- flush_d=1 at an edge, with rst_n=1: main and skid become invalid; ins_d, lane_mask_d and pc_plus1_d become 0 (all-zero NOP); the skid payload becomes 0.
- Any bundle offered in that cycle is dropped, even if in_valid & in_ready.
- flush_d takes priority over stall_d and over accept.
- Consecutive flush cycles keep the stage empty.

Counters
- Each counter increments by 1 per qualifying cycle.
- A counter holds at 2^CNT_W-1 and does not wrap.
- Counters are cleared only by reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → valid_d=0, ins_d=0, pc_plus1_d=0, in_ready=1, both counters 0. On release, a bundle ins_f=0x00A0_0013, pc_plus1_f=5 → valid_d=1 with ins_d=0x00A0_0013, pc_plus1_d=5 one cycle later.
- Stall skid: stream bundles A(pc 1), B(pc 2), C(pc 3) on consecutive cycles; raise stall_d when A sits in main → B enters skid, in_ready=0, C is held at the input. Release stall_d → Decode sees A, B, C in order with no loss and no duplicate.
- Flush over stall: main=A, skid=B, stall_d=1, flush_d=1, in_valid=1 with C → next cycle valid_d=0, ins_d=0, lane_mask_d=0, in_ready=1, flush_cnt=1; C is not delivered.
- LANES=2: ins_f={0x1111_1111, 0x2222_2222}, lane_mask_f=2'b01 → ins_d and lane_mask_d=2'b01 match exactly. Mask 2'b00 with in_valid=1 → valid_d=1, lane_mask_d=0.
- Bubbles: leave in_valid=0 for 10 cycles with stall_d=0 and flush_d=0 → bubble_cnt=10. With CNT_W=4, hold the same condition for 20 cycles → bubble_cnt saturates at 15.
- Reset mid-operation: main and skid full, stall_d=1, assert rst_n=0 for one edge → all state cleared; the next accepted bundle appears alone with 1-cycle latency.
